// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue scheduler for the decode stage.
// Tracks per-register writeback countdowns and stalls on RAW, WAW and writeback port conflicts.
`timescale 1ns/1ps
module issue_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int LATW    = 3,
  parameter int DEF_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_regw,
  input  logic [LATW-1:0] issue_lat,
  input  logic            flush,
  output logic            stall,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            bubble,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_rd,
  output logic [NREG-1:0] busy_vec,
  output logic [15:0]     stall_cnt
);

  logic [LATW-1:0] cnt [NREG];
  logic [LATW-1:0] eff_lat;
  logic [LATW-1:0] eff_lat_p1;
  logic [NREG-1:0] port_hit;
  logic [NREG-1:0] wb_hit;
  logic            rd_tracked;
  logic            raw_haz;
  logic            waw_haz;
  logic            port_haz;
  logic            raw_stall;
  logic            accept;
  logic            set_rd;

  assign eff_lat    = (issue_lat == '0) ? LATW'(DEF_LAT) : issue_lat;
  assign eff_lat_p1 = eff_lat + LATW'(1);
  assign rd_tracked = issue_regw && (issue_rd != '0);

  always_comb begin
    busy_vec = '0;
    port_hit = '0;
    wb_hit   = '0;
    wb_valid = 1'b0;
    wb_rd    = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_vec[r] = (cnt[r] != '0);
      port_hit[r] = (cnt[r] == eff_lat_p1);
      wb_hit[r]   = (cnt[r] == LATW'(1));
      if (wb_hit[r]) begin
        wb_valid = 1'b1;
        wb_rd    = AW'(r);
      end
    end
  end

  // busy_vec[0] is constant zero, so register 0 as a source never hazards
  assign raw_haz   = busy_vec[issue_rs] || busy_vec[issue_rt];
  assign waw_haz   = rd_tracked && busy_vec[issue_rd];
  assign port_haz  = rd_tracked && (port_hit != '0);
  assign raw_stall = issue_valid && (raw_haz || waw_haz || port_haz);

  assign stall      = raw_stall && !flush;
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign bubble     = stall || flush;
  assign accept     = issue_valid && !stall && !flush;
  assign set_rd     = accept && rd_tracked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (set_rd && (issue_rd == AW'(r)))
          cnt[r] <= eff_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LATW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  // The port-conflict stall guarantees at most one register completes per edge
  a_single_wb: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wb_hit))
    else $error("issue_scoreboard: multiple writebacks in one cycle");

  a_legal_lat: assert property (@(posedge clk) disable iff (!rst_n)
    issue_valid |-> (issue_lat <= LATW'((1 << LATW) - 2)))
    else $error("issue_scoreboard: illegal issue_lat %0d", issue_lat);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stall expectations checked inline,
// writebacks checked by a monitor against a queue of expected completions.
`timescale 1ns/1ps
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_regw;
  logic [2:0]  issue_lat;
  logic        flush;
  logic        stall, pc_write, ifid_write, bubble, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  issue_scoreboard #(.NREG(32), .AW(5), .LATW(3), .DEF_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_regw(issue_regw), .issue_lat(issue_lat), .flush(flush),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .bubble(bubble), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] rd;
    int         at;
  } wb_exp_t;
  wb_exp_t wb_q[$];

  int tests = 0;
  int failed = 0;
  int quiet_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writeback monitor: every reported writeback must match an expected entry for this cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wb_valid) begin
        int idx;
        idx = -1;
        foreach (wb_q[i]) if (idx < 0 && wb_q[i].at == cyc) idx = i;
        if (idx < 0) begin
          check("wb_unexpected", {27'd0, wb_rd}, 32'h0);
          if (wb_rd == 5'd0) begin
            failed++;
            $display("FAIL wb_unexpected: got wb_valid 1 expected 0 (cycle %0d)", cyc);
          end
        end else begin
          check("wb_rd", {27'd0, wb_rd}, {27'd0, wb_q[idx].rd});
          wb_q.delete(idx);
        end
      end else begin
        if (wb_rd !== 5'd0) check("wb_rd_idle", {27'd0, wb_rd}, 32'h0);
      end
      foreach (wb_q[i]) if (wb_q[i].at < cyc) begin
        check("wb_missing", 32'h0, {27'd0, wb_q[i].rd});
        wb_q[i].at = 32'h7FFFFFFF;
      end
    end
  end

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic regw, input logic [2:0] lat,
                      input logic fl, input logic exp_stall, input string name, input bit quiet);
    int l;
    issue_valid = v; issue_rs = rs; issue_rt = rt; issue_rd = rd;
    issue_regw = regw; issue_lat = lat; flush = fl;
    @(negedge clk);
    if (quiet) begin
      if (stall !== exp_stall) quiet_err++;
    end else begin
      check({name, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
      check({name, "_bubble"}, {31'd0, bubble}, {31'd0, exp_stall | fl});
      check({name, "_pcw"}, {31'd0, pc_write}, {31'd0, ~exp_stall});
    end
    l = (lat == 3'd0) ? 2 : int'(lat);
    if (v && !exp_stall && !fl && regw && rd != 5'd0) begin
      wb_exp_t e;
      e.rd = rd;
      e.at = cyc + l;
      wb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, "idle", 1'b1);
  endtask

  initial begin
    int prev, nxt;
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_rd = '0;
    issue_regw = 1'b0; issue_lat = '0; flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_pcw", {31'd0, pc_write}, 32'd1);
    check("rst_ifidw", {31'd0, ifid_write}, 32'd1);
    check("rst_bubble_flush", {31'd0, bubble}, 32'd1);
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    check("rst_scnt", {16'd0, stall_cnt}, 32'd0);
    flush = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", busy_vec, 32'd0);

    // RAW with default latency
    step(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0, "raw_prod", 1'b0);
    check("raw_busy5", busy_vec, 32'h20);
    step(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, "raw_s1", 1'b0);
    step(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, "raw_s2", 1'b0);
    step(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, "raw_acc", 1'b0);
    check("raw_scnt", {16'd0, stall_cnt}, 32'd2);

    // Register zero is never tracked
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, "r0_wr", 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, "r0_rd", 1'b0);
    check("r0_busy", busy_vec, 32'd0);

    // Port conflict then WAW
    step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd5, 1'b0, 1'b0, "pc_r3", 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 3'd4, 1'b0, 1'b1, "pc_conf", 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 3'd4, 1'b0, 1'b0, "pc_acc", 1'b0);
    check("pc_busy", busy_vec, 32'h18);
    step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd0, 1'b0, 1'b1, "waw_s1", 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd0, 1'b0, 1'b1, "waw_s2", 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd0, 1'b0, 1'b1, "waw_s3", 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd0, 1'b0, 1'b0, "waw_acc", 1'b0);
    check("waw_scnt", {16'd0, stall_cnt}, 32'd6);
    idle(3);

    // Flush beats a hazard
    step(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0, "fl_prod", 1'b0);
    step(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 3'd0, 1'b1, 1'b0, "fl_kill", 1'b0);
    check("fl_busy", busy_vec, 32'h20);
    check("fl_scnt", {16'd0, stall_cnt}, 32'd6);
    idle(3);
    check("drain_busy", busy_vec, 32'd0);

    // Saturation: ping-pong between r1 and r2 with latency 6, six stalls per op
    step(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 3'd6, 1'b0, 1'b0, "sat", 1'b1);
    prev = 1;
    for (int it = 0; it < 11000; it++) begin
      nxt = (prev == 1) ? 2 : 1;
      for (int j = 0; j < 6; j++)
        step(1'b1, 5'(prev), 5'd0, 5'(nxt), 1'b1, 3'd6, 1'b0, 1'b1, "sat", 1'b1);
      step(1'b1, 5'(prev), 5'd0, 5'(nxt), 1'b1, 3'd6, 1'b0, 1'b0, "sat", 1'b1);
      prev = nxt;
    end
    check("sat_pattern_errs", quiet_err, 32'd0);
    check("sat_scnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    step(1'b1, 5'(prev), 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, "sat_more", 1'b0);
    check("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

    // Asynchronous reset mid-cycle with work pending
    issue_valid = 1'b1; issue_rs = 5'(prev); issue_regw = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_vec, 32'd0);
    check("arst_scnt", {16'd0, stall_cnt}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_wbv", {31'd0, wb_valid}, 32'd0);
    wb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 5'(prev), 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, "arst_resume", 1'b0);
    idle(8);
    check("queue_empty", wb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
